// File: rtl/axi_mon_pkg.sv
// Shared AXI monitor types: prescaler FSM states and the sticky R-channel flag bundle.
package axi_mon_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } presc_state_e;

    typedef struct packed {
        logic valid;
        logic ready;
        logic last;
    } rd_sticky_t;

    // Per-cycle R-channel contribution: last only counts on a completed handshake.
    function automatic rd_sticky_t rd_terms(logic valid, logic ready, logic last);
        rd_sticky_t t;
        t.valid = valid;
        t.ready = ready;
        t.last  = valid & ready & last;
        return t;
    endfunction

endpackage

// File: rtl/presc_tick_gen.sv
// Prescale window generator: IDLE/RUN FSM, window counter and boundary-latched divisor.
// close_o marks the last cycle of an open window; run_o marks cycles that belong to a window.
module presc_tick_gen
    import axi_mon_pkg::*;
#(
    parameter int unsigned PrescWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [PrescWidth-1:0] presc_div_i,
    output logic                  run_o,
    output logic                  close_o
);

    presc_state_e          state_q, state_d;
    logic [PrescWidth-1:0] cnt_q, cnt_d;
    logic [PrescWidth-1:0] div_q, div_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (enable_i)  state_d = StRun;
            StRun:   if (!enable_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        run_o   = (state_q == StRun) && enable_i;
        close_o = run_o && (cnt_q == div_q);
    end

    // Divisor is only sampled on entry to RUN and at window boundaries.
    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        if (state_q != StRun) begin
            cnt_d = '0;
            if (enable_i) div_d = presc_div_i;
        end else if (!enable_i) begin
            cnt_d = '0;
        end else if (close_o) begin
            cnt_d = '0;
            div_d = presc_div_i;
        end else begin
            cnt_d = cnt_q + PrescWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/rd_sticky_prescaler.sv
// Prescaled tick plus per-window sticky R-channel flags for the read-slot counters.
// Optional per-window beat count enabled by defining AXI_MON_BEATCNT_EN.
module rd_sticky_prescaler
    import axi_mon_pkg::*;
#(
    parameter int unsigned PrescWidth   = 8,
    parameter int unsigned BeatCntWidth = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [PrescWidth-1:0]   presc_div_i,
    input  logic                    r_valid_i,
    input  logic                    r_ready_i,
    input  logic                    r_last_i,
    output logic                    prescaled_en_o,
    output logic                    r_valid_sticky_o,
    output logic                    r_ready_sticky_o,
    output logic                    r_last_sticky_o,
    output logic [BeatCntWidth-1:0] r_beats_o
);

    logic       run;
    logic       close;
    logic       tick_q;
    rd_sticky_t acc_q, sticky_q, acc_or;

    presc_tick_gen #(
        .PrescWidth (PrescWidth)
    ) u_tick_gen (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .presc_div_i (presc_div_i),
        .run_o       (run),
        .close_o     (close)
    );

    // Closing-cycle inputs fold into the window being published.
    assign acc_or = rd_sticky_t'(acc_q | rd_terms(r_valid_i, r_ready_i, r_last_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_q   <= 1'b0;
            acc_q    <= '0;
            sticky_q <= '0;
        end else begin
            tick_q <= close;
            if (close) begin
                sticky_q <= acc_or;
                acc_q    <= '0;
            end else if (run) begin
                acc_q <= acc_or;
            end else begin
                acc_q <= '0;
            end
        end
    end

`ifdef AXI_MON_BEATCNT_EN
    logic [BeatCntWidth-1:0] beat_acc_q, beats_q, beat_sum;

    always_comb begin
        beat_sum = beat_acc_q;
        if (r_valid_i && r_ready_i && (beat_acc_q != '1)) begin
            beat_sum = beat_acc_q + BeatCntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_acc_q <= '0;
            beats_q    <= '0;
        end else if (close) begin
            beats_q    <= beat_sum;
            beat_acc_q <= '0;
        end else if (run) begin
            beat_acc_q <= beat_sum;
        end else begin
            beat_acc_q <= '0;
        end
    end

    assign r_beats_o = beats_q;
`else
    assign r_beats_o = '0;
`endif

    assign prescaled_en_o   = tick_q;
    assign r_valid_sticky_o = sticky_q.valid;
    assign r_ready_sticky_o = sticky_q.ready;
    assign r_last_sticky_o  = sticky_q.last;

endmodule
